// File: rtl/result_readout_if.sv
// Result readout bus: compute results in, presented word out.
// Signals: done, g, h, key_n (to block); word_out, word_idx, valid, parity_out (from block).
interface result_readout_if #(
   parameter int WIDTH = 16
);
   logic             done;
   logic [WIDTH-1:0] g;
   logic [WIDTH-1:0] h;
   logic             key_n;
   logic [WIDTH-1:0] word_out;
   logic [1:0]       word_idx;
   logic             valid;
   logic             parity_out;

   modport master (
      output done, g, h, key_n,
      input  word_out, word_idx, valid, parity_out
   );

   modport slave (
      input  done, g, h, key_n,
      output word_out, word_idx, valid, parity_out
   );
endinterface

// File: rtl/result_readout.sv
// Snapshots g/h on done, presents g, h, g+h, popcounts; KEY[0] release steps.
// Ports: CLOCK_50, rst (async, active-low), bus (slave). Option: RESULT_PARITY_EN.
module result_readout #(
   parameter int WIDTH      = 16,
   parameter int DEB_CYCLES = 1000
) (
   input logic         CLOCK_50,
   input logic         rst,
   result_readout_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE, CAPTURE, SHOW, HELD
   } state_t;

   localparam int CLG  = $clog2(DEB_CYCLES + 1);
   localparam int CW   = (CLG > 20) ? CLG : 20;
   localparam int HALF = WIDTH / 2;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX  = '1;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] gs_q, gs_d;
   logic [WIDTH-1:0] hs_q, hs_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic             valid_q, valid_d;
   logic             key_act;
   logic [CW-1:0]    cnt_inc;

   function automatic logic [4:0] pop5(
      input logic [WIDTH-1:0] v
   );
      logic [4:0] n;
      n = '0;
      for (int i = 0; i < WIDTH; i++)
         n = n + 5'(v[i]);
      return n;
   endfunction

   function automatic logic [WIDTH-1:0] word_sel(
      input logic [1:0]       idx,
      input logic [WIDTH-1:0] gv,
      input logic [WIDTH-1:0] hv
   );
      logic [WIDTH-1:0] w;
      w = '0;
      case (idx)
         2'd0: w = gv;
         2'd1: w = hv;
         2'd2: w = gv + hv;
         default: begin
            w[4:0]           = pop5(hv);
            w[HALF+4:HALF]   = pop5(gv);
         end
      endcase
      return w;
   endfunction

   always_ff @(posedge CLOCK_50 or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         gs_q    <= '0;
         hs_q    <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         word_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         gs_q    <= gs_d;
         hs_q    <= hs_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
         valid_q <= valid_d;
      end
   end

   // SHOW waits for a qualified press, HELD for a qualified release.
   assign key_act = (state_q == SHOW) ? ~bus.key_n : bus.key_n;
   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

   always_comb begin
      state_d = state_q;
      gs_d    = gs_q;
      hs_d    = hs_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      word_d  = word_q;
      valid_d = valid_q;
      // Loss of done beats any key qualification.
      if (state_q != IDLE && !bus.done) begin
         state_d = IDLE;
         cnt_d   = '0;
         idx_d   = '0;
         word_d  = '0;
         valid_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.done)
                  state_d = CAPTURE;
            end
            CAPTURE: begin
               gs_d    = bus.g;
               hs_d    = bus.h;
               word_d  = bus.g;
               idx_d   = '0;
               valid_d = 1'b1;
               cnt_d   = '0;
               state_d = SHOW;
            end
            default: begin
               if (!key_act) begin
                  cnt_d = '0;
               end else if (cnt_q >= CNT_LAST) begin
                  cnt_d = '0;
                  if (state_q == SHOW) begin
                     state_d = HELD;
                  end else begin
                     state_d = SHOW;
                     idx_d   = idx_q + 2'd1;
                     word_d  = word_sel(idx_q + 2'd1,
                                        gs_q, hs_q);
                  end
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         endcase
      end
   end

   assign bus.word_out = word_q;
   assign bus.word_idx = idx_q;
   assign bus.valid    = valid_q;

`ifdef RESULT_PARITY_EN
   logic par_q;

   always_ff @(posedge CLOCK_50 or negedge rst) begin
      if (!rst)
         par_q <= 1'b0;
      else
         par_q <= valid_d ? ~^word_d : 1'b0;
   end

   assign bus.parity_out = par_q;
`else
   assign bus.parity_out = 1'b0;
`endif

endmodule
